// File: rtl/keypad_scan_if.sv
// Keypad scanner pin/event bundle. The master side is the scanner and the
// slave side is the keypad/consumer view of the same wires.
interface keypad_scan_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int IDXW = $clog2(ROWS*COLS);

  logic [ROWS-1:0] row_drive;
  logic [COLS-1:0] col_sense;
  logic [IDXW-1:0] key_code;
  logic            key_valid;
  logic            key_held;
  logic            multi_key;

  modport master (
    output row_drive, key_code, key_valid, key_held, multi_key,
    input  col_sense
  );

  modport slave (
    input  row_drive, key_code, key_valid, key_held, multi_key,
    output col_sense
  );
endinterface

// File: rtl/keypad_scan_encoder.sv
// Row/column matrix keypad scanner with per-frame debounce. Emits one
// key_valid per new stable single key and multi_key for stable chords.
module keypad_scan_encoder #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int SCAN_CYCLES = 4,
  parameter int DEBOUNCE    = 3
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master bus
);
  localparam int N    = ROWS*COLS;
  localparam int IDXW = $clog2(N);
  localparam int DW   = $clog2(SCAN_CYCLES);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(DEBOUNCE+1);

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;
  typedef enum logic {SCAN_ROW, EVAL} state_e;

  // idx is forced to 0 for NONE/MULTI so whole-struct compares are exact
  typedef struct packed {
    cls_e            cls;
    logic [IDXW-1:0] idx;
  } key_state_t;

  state_e          state;
  logic [DW-1:0]   dwell;
  logic [RW-1:0]   row;
  logic [ROWS-1:0] row_drive;
  logic [N-1:0]    acc;
  logic [N-1:0]    frame;
  logic [N-1:0]    samp;
  key_state_t      cand;
  key_state_t      acpt;
  key_state_t      cur;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   nxt_cnt;
  logic [1:0]      hits;
  logic            accept;
  logic            last_dwell;
  logic            last_row;
  logic [IDXW-1:0] key_code_q;
  logic            key_valid_q;
  logic            key_held_q;
  logic            multi_key_q;

  assign last_dwell = (dwell == DW'(SCAN_CYCLES-1));
  assign last_row   = (row == RW'(ROWS-1));

  // Accumulator with the currently driven row's columns merged in
  always_comb begin
    samp = acc;
    for (int r = 0; r < ROWS; r++)
      if (row == RW'(r)) samp[r*COLS +: COLS] = bus.col_sense;
  end

  always_comb begin
    hits    = 2'd0;
    cur.idx = '0;
    for (int i = 0; i < N; i++) begin
      if (frame[i]) begin
        if (hits == 2'd0) cur.idx = IDXW'(i);
        if (hits != 2'd2) hits = hits + 2'd1;
      end
    end
    case (hits)
      2'd0:    cur.cls = CLS_NONE;
      2'd1:    cur.cls = CLS_SINGLE;
      default: cur.cls = CLS_MULTI;
    endcase
    if (cur.cls != CLS_SINGLE) cur.idx = '0;
    if (cur == cand) nxt_cnt = (cnt == CW'(DEBOUNCE)) ? cnt : cnt + CW'(1);
    else             nxt_cnt = CW'(1);
    accept = (nxt_cnt == CW'(DEBOUNCE)) && (cur != acpt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN_ROW;
      dwell       <= '0;
      row         <= '0;
      row_drive   <= ROWS'(1);
      acc         <= '0;
      frame       <= '0;
      cand        <= '{cls: CLS_NONE, idx: '0};
      acpt        <= '{cls: CLS_NONE, idx: '0};
      cnt         <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      multi_key_q <= 1'b0;

      if (last_dwell) begin
        dwell     <= '0;
        row_drive <= {row_drive[ROWS-2:0], row_drive[ROWS-1]};
        if (last_row) begin
          row   <= '0;
          frame <= samp;
          acc   <= '0;
        end else begin
          row <= row + RW'(1);
          acc <= samp;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end

      // EVAL overlaps row 0's first dwell cycle; scanning never pauses
      case (state)
        SCAN_ROW: if (last_dwell && last_row) state <= EVAL;
        EVAL: begin
          state <= SCAN_ROW;
          cand  <= cur;
          cnt   <= nxt_cnt;
          if (accept) begin
            acpt <= cur;
            case (cur.cls)
              CLS_SINGLE: begin
                key_code_q  <= cur.idx;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end
              CLS_MULTI: begin
                multi_key_q <= 1'b1;
                key_held_q  <= 1'b0;
              end
              default: key_held_q <= 1'b0;
            endcase
          end
        end
        default: state <= SCAN_ROW;
      endcase
    end
  end

  assign bus.row_drive = row_drive;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;
  assign bus.multi_key = multi_key_q;
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Scoreboard bench: per-frame keypad model queues expected accept events,
// a negedge monitor pops them and checks every output each cycle.
module tb_keypad_scan_encoder;
  localparam int ROWS = 4, COLS = 4, SC = 4, DB = 3;
  localparam int N = ROWS*COLS;
  localparam int F = ROWS*SC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_if #(.ROWS(ROWS), .COLS(COLS)) kif();
  keypad_scan_if #(.ROWS(2), .COLS(3)) kif2();

  keypad_scan_encoder #(.ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(SC), .DEBOUNCE(DB))
    dut (.clk(clk), .rst(rst), .bus(kif));
  keypad_scan_encoder #(.ROWS(2), .COLS(3), .SCAN_CYCLES(2), .DEBOUNCE(1))
    dut2 (.clk(clk), .rst(rst2), .bus(kif2));

  logic [N-1:0] pressed = '0;

  // Keypad matrix: a closed key shorts its row strobe onto its column
  always_comb begin
    kif.col_sense = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (kif.row_drive[r] && pressed[r*COLS+c]) kif.col_sense[c] = 1'b1;
  end
  // Small keypad: key at row 1 / col 2 held down permanently
  always_comb kif2.col_sense = kif2.row_drive[1] ? 3'b100 : 3'b000;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int unsigned cyc = 0;
  int unsigned cyc2 = 0;
  always @(posedge clk) if (rst) cyc <= 0; else cyc <= cyc + 1;
  always @(posedge clk) if (rst2) cyc2 <= 0; else cyc2 <= cyc2 + 1;

  // Class encoding: -1 none, -2 multi, >=0 single key index
  typedef struct {int unsigned at; int cls;} ev_t;
  ev_t evq[$];
  int  hist[$];
  int  acc_cls = -1;
  int  fk = 0;

  function automatic int classify(input logic [N-1:0] p);
    if ($countones(p) == 0) return -1;
    if ($countones(p) > 1) return -2;
    for (int i = 0; i < N; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] key(input int i);
    logic [N-1:0] p;
    p = '0;
    p[i] = 1'b1;
    return p;
  endfunction

  // A class is accepted once the last DB frames all agree and it is new
  task automatic model_frame(input logic [N-1:0] p);
    int  c;
    bit  stable;
    c = classify(p);
    hist.push_back(c);
    if (hist.size() > DB) void'(hist.pop_front());
    stable = (hist.size() == DB);
    foreach (hist[j]) if (hist[j] != c) stable = 0;
    if (stable && c != acc_cls) begin
      acc_cls = c;
      evq.push_back('{at: (fk+1)*F + 1, cls: c});
    end
    fk++;
  endtask

  task automatic run_frames(input logic [N-1:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      pressed = p;
      model_frame(p);
      repeat (F) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    chk("events_pending_at_reset", evq.size(), 0);
    evq.delete();
    hist.delete();
    acc_cls = -1;
    fk = 0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int  code_exp = 0;
  bit  held_exp = 0;
  bit  v_exp, m_exp;
  ev_t ev;

  always @(negedge clk) begin
    if (rst) begin
      code_exp = 0;
      held_exp = 0;
    end else begin
      v_exp = 0;
      m_exp = 0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (ev.cls >= 0) begin
          v_exp = 1; code_exp = ev.cls; held_exp = 1;
        end else if (ev.cls == -2) begin
          m_exp = 1; held_exp = 0;
        end else begin
          held_exp = 0;
        end
      end
      chk("row_drive", int'(kif.row_drive), 1 << ((cyc / SC) % ROWS));
      chk("key_valid", int'(kif.key_valid), int'(v_exp));
      chk("multi_key", int'(kif.multi_key), int'(m_exp));
      chk("key_code",  int'(kif.key_code), code_exp);
      chk("key_held",  int'(kif.key_held), int'(held_exp));
    end
  end

  // Small instance: F=4, DEBOUNCE=1, so key 5 is accepted at cycle 5
  always @(negedge clk) begin
    if (!rst2 && cyc2 < 40) begin
      chk("p_row_drive", int'(kif2.row_drive), 1 << ((cyc2 / 2) % 2));
      chk("p_key_valid", int'(kif2.key_valid), (cyc2 == 5) ? 1 : 0);
      chk("p_key_code",  int'(kif2.key_code), (cyc2 >= 5) ? 5 : 0);
      chk("p_key_held",  int'(kif2.key_held), (cyc2 >= 5) ? 1 : 0);
      chk("p_multi_key", int'(kif2.multi_key), 0);
    end
  end

  initial begin
    logic [N-1:0] p;
    int a, b, k;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rst2 = 1'b0;

    run_frames('0, 2);
    run_frames(key(9), 5);
    run_frames('0, 4);
    for (int i = 0; i < 4; i++) begin
      run_frames(key(5), 1);
      run_frames('0, 1);
    end
    run_frames(key(9), 4);
    run_frames(key(4) | key(7), 4);
    run_frames('0, 4);
    run_frames(key(3), 4);
    run_frames(key(14), 4);
    run_frames('0, 4);

    for (int s = 0; s < 40; s++) begin
      k = $urandom_range(0, 9);
      a = $urandom_range(0, N-1);
      b = (a + 1 + $urandom_range(0, N-2)) % N;
      if (k < 3)      p = '0;
      else if (k < 8) p = key(a);
      else            p = key(a) | key(b);
      run_frames(p, $urandom_range(1, 4));
    end
    run_frames('0, 4);

    run_frames(key(7), 2);
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    run_frames(key(7), 4);
    run_frames('0, 4);
    repeat (F) @(posedge clk);
    #1;
    chk("events_drained", evq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
